// File: rtl/pifo_mon_pkg.sv
// Shared types and constants for the PIFO output stream monitor.
package pifo_mon_pkg;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mon_state_t;

  // Default SUME metadata field offsets inside tuser
  localparam int SUME_CHAN_LSB = 24;
  localparam int SUME_RANK_LSB = 32;

  localparam int CNT_WIDTH = 32;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pifo_mon_idle_timer.sv
// Idle counter and WAIT/RUN/DONE state machine; done is sticky until clear.
module pifo_mon_idle_timer
  import pifo_mon_pkg::*;
#(
  parameter int unsigned IDLE_LIMIT = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       beat,
  input  logic       arm,
  input  logic       clear,
  output logic       done,
  output mon_state_t state
);

  localparam logic [CNT_WIDTH-1:0] LIMIT    = CNT_WIDTH'(IDLE_LIMIT);
  localparam logic [CNT_WIDTH-1:0] LIMIT_M1 = CNT_WIDTH'(IDLE_LIMIT - 1);

  mon_state_t           state_reg, state_next;
  logic [CNT_WIDTH-1:0] idle_cnt_reg, idle_cnt_next;
  logic                 done_reg, done_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_WAIT;
      idle_cnt_reg <= '0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      idle_cnt_reg <= idle_cnt_next;
      done_reg     <= done_next;
    end
  end

  // Once the limit is reached the count parks at LIMIT, so a late arm still fires
  always_comb begin
    state_next    = state_reg;
    idle_cnt_next = idle_cnt_reg;
    if (clear) begin
      state_next    = ST_WAIT;
      idle_cnt_next = '0;
    end else begin
      case (state_reg)
        ST_WAIT: begin
          if (beat) begin
            state_next    = ST_RUN;
            idle_cnt_next = '0;
          end
        end
        ST_RUN: begin
          if (beat) begin
            idle_cnt_next = '0;
          end else if (idle_cnt_reg >= LIMIT_M1) begin
            idle_cnt_next = LIMIT;
            if (arm) state_next = ST_DONE;
          end else begin
            idle_cnt_next = idle_cnt_reg + CNT_WIDTH'(1);
          end
        end
        ST_DONE: state_next = ST_DONE;
        default: state_next = ST_WAIT;
      endcase
    end
  end

  always_comb begin
    done_next = (state_next == ST_DONE);
    done      = done_reg;
    state     = state_reg;
  end

endmodule

// File: rtl/pifo_stream_monitor.sv
// Passive AXI-Stream tap: per-channel rank-order check, packet counts, idle done flag.
// Optional protocol checker enabled by defining PIFO_MON_PROTO_CHECK_EN.
module pifo_stream_monitor
  import pifo_mon_pkg::*;
#(
  parameter int          DATA_WIDTH      = 256,
  parameter int          SUME_META_WIDTH = 168,
  parameter int          NUM_CHANNELS    = 4,
  parameter int          CHAN_LSB        = SUME_CHAN_LSB,
  parameter int          RANK_LSB        = SUME_RANK_LSB,
  parameter int          RANK_WIDTH      = 16,
  parameter int unsigned IDLE_LIMIT      = 1000
) (
  input  logic                              clk_in_0,
  input  logic                              reset,
  input  logic [DATA_WIDTH-1:0]             mon_tdata,
  input  logic [SUME_META_WIDTH-1:0]        mon_tuser,
  input  logic                              mon_tvalid,
  input  logic                              mon_tready,
  input  logic                              mon_tlast,
  input  logic                              arm,
  input  logic                              clear,
  output logic                              done,
  output logic                              order_err,
  output logic [15:0]                       order_err_cnt,
  output logic [3:0]                        err_chan,
  output logic [CNT_WIDTH*NUM_CHANNELS-1:0] pkt_cnt,
  output logic                              proto_err
);

  localparam int CHAN_W     = clog2(NUM_CHANNELS);
  localparam int CHAN_IDX_W = (CHAN_W == 0) ? 1 : CHAN_W;

  logic                    beat;
  logic                    sop_reg;
  logic [CHAN_IDX_W-1:0]   sop_chan, pkt_chan, chan_latched_reg;
  logic [RANK_WIDTH-1:0]   sop_rank;
  logic [NUM_CHANNELS-1:0] violation;
  logic                    any_violation;
  logic                    order_err_reg;
  logic [15:0]             order_err_cnt_reg;
  logic [3:0]              err_chan_reg;
  mon_state_t              timer_state;
  logic                    unused_bits;

  assign beat          = mon_tvalid & mon_tready;
  assign sop_rank      = mon_tuser[RANK_LSB +: RANK_WIDTH];
  assign pkt_chan      = sop_reg ? sop_chan : chan_latched_reg;
  assign any_violation = |violation;
  assign unused_bits   = ^{mon_tdata, mon_tuser, timer_state};

  generate
    if (CHAN_W == 0) begin : g_one_chan
      assign sop_chan = '0;
    end else begin : g_multi_chan
      assign sop_chan = mon_tuser[CHAN_LSB +: CHAN_W];
    end
  endgenerate

  // clear masks the colliding beat so it is neither checked nor counted
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
      logic                  sop_hit, eop_hit, seen_reg;
      logic [RANK_WIDTH-1:0] last_rank_reg;
      logic [CNT_WIDTH-1:0]  pkt_cnt_reg;

      assign sop_hit = beat & ~clear & sop_reg & (sop_chan == CHAN_IDX_W'(gi));
      assign eop_hit = beat & ~clear & mon_tlast & (pkt_chan == CHAN_IDX_W'(gi));
      assign violation[gi] = sop_hit & seen_reg & (sop_rank < last_rank_reg);
      assign pkt_cnt[gi*CNT_WIDTH +: CNT_WIDTH] = pkt_cnt_reg;

      always_ff @(posedge clk_in_0 or negedge reset) begin
        if (!reset) begin
          seen_reg      <= 1'b0;
          last_rank_reg <= '0;
          pkt_cnt_reg   <= '0;
        end else if (clear) begin
          seen_reg      <= 1'b0;
          last_rank_reg <= '0;
          pkt_cnt_reg   <= '0;
        end else begin
          if (sop_hit) begin
            seen_reg      <= 1'b1;
            last_rank_reg <= sop_rank;
          end
          if (eop_hit && pkt_cnt_reg != '1) pkt_cnt_reg <= pkt_cnt_reg + CNT_WIDTH'(1);
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_in_0 or negedge reset) begin
    if (!reset) begin
      sop_reg           <= 1'b1;
      chan_latched_reg  <= '0;
      order_err_reg     <= 1'b0;
      order_err_cnt_reg <= '0;
      err_chan_reg      <= '0;
    end else if (clear) begin
      sop_reg           <= 1'b1;
      chan_latched_reg  <= '0;
      order_err_reg     <= 1'b0;
      order_err_cnt_reg <= '0;
      err_chan_reg      <= '0;
    end else begin
      if (beat) begin
        sop_reg <= mon_tlast;
        if (sop_reg) chan_latched_reg <= sop_chan;
      end
      if (any_violation) begin
        order_err_reg <= 1'b1;
        if (order_err_cnt_reg != '1) order_err_cnt_reg <= order_err_cnt_reg + 16'd1;
        if (!order_err_reg) err_chan_reg <= 4'(sop_chan);
      end
    end
  end

  assign order_err     = order_err_reg;
  assign order_err_cnt = order_err_cnt_reg;
  assign err_chan      = err_chan_reg;

  pifo_mon_idle_timer #(
    .IDLE_LIMIT(IDLE_LIMIT)
  ) u_idle_timer (
    .clk  (clk_in_0),
    .rst_n(reset),
    .beat (beat),
    .arm  (arm),
    .clear(clear),
    .done (done),
    .state(timer_state)
  );

`ifdef PIFO_MON_PROTO_CHECK_EN
  logic                       stall, dropped, changed;
  logic                       stall_reg, proto_err_reg;
  logic [DATA_WIDTH-1:0]      hold_data_reg;
  logic [SUME_META_WIDTH-1:0] hold_user_reg;
  logic                       hold_last_reg;

  assign stall   = mon_tvalid & ~mon_tready;
  assign dropped = stall_reg & ~mon_tvalid;
  assign changed = stall_reg & mon_tvalid &
                   ((mon_tdata != hold_data_reg) | (mon_tuser != hold_user_reg) |
                    (mon_tlast != hold_last_reg));

  // Payload snapshot needs no reset: it is only compared while stall_reg is set
  always_ff @(posedge clk_in_0) begin
    if (stall) begin
      hold_data_reg <= mon_tdata;
      hold_user_reg <= mon_tuser;
      hold_last_reg <= mon_tlast;
    end
  end

  always_ff @(posedge clk_in_0 or negedge reset) begin
    if (!reset) begin
      stall_reg     <= 1'b0;
      proto_err_reg <= 1'b0;
    end else if (clear) begin
      stall_reg     <= 1'b0;
      proto_err_reg <= 1'b0;
    end else begin
      stall_reg <= stall;
      if (dropped | changed) proto_err_reg <= 1'b1;
    end
  end

  assign proto_err = proto_err_reg;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: doc/pifo_stream_monitor.md
# pifo_stream_monitor

Synthesizable, passive monitor that taps the master AXI-Stream output of the PIFO module, checks per-channel rank ordering, counts packets, and raises a done flag after a programmable number of idle cycles. It generalises the bench-only idle-stop check to N channels, a parametrised idle limit and an AXI-Stream protocol checker. The monitor sits beside the PIFO output in both simulation and hardware builds and never drives the stream.

## Interface
- DATA_WIDTH, 256, tapped tdata width.
- SUME_META_WIDTH, 168, tapped tuser width.
- NUM_CHANNELS, 4, channels tracked; power of two, 1..16.
- CHAN_LSB, 24, tuser bit offset of the channel index; the index is log2(NUM_CHANNELS) bits wide, 0 bits when NUM_CHANNELS=1.
- RANK_LSB, 32, tuser bit offset of the rank.
- RANK_WIDTH, 16, rank width; unsigned.
- IDLE_LIMIT, 1000, idle cycles before done; 1..2^32-1.

Ports:
- clk_in_0  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- mon_tdata  in  DATA_WIDTH  tapped tdata.
- mon_tuser  in  SUME_META_WIDTH  tapped tuser.
- mon_tvalid / mon_tready / mon_tlast  in  1 each  tapped handshake.
- arm  in  1  enables done assertion; level.
- clear  in  1  synchronous clear of counters and flags.
- done  out  1  sticky; idle limit reached while armed.
- order_err  out  1  sticky rank-order violation.
- order_err_cnt  out  16  violation count, saturating.
- err_chan  out  4  channel of first violation.
- pkt_cnt  out  32*NUM_CHANNELS  per-channel packet count, channel c at [32c +: 32], saturating.
- proto_err  out  1  sticky AXIS protocol violation; tied 0 when checker is compiled out.

## Operation
- Beat = mon_tvalid & mon_tready. SOP = first beat after reset, after clear, or after a beat with tlast.
- Channel and rank sampled only on SOP beats.
- On SOP: if rank < last_rank[ch] and seen[ch] is set, set order_err, increment order_err_cnt, and latch err_chan on the first violation only. Then update last_rank[ch] and set seen[ch]. Equal ranks are legal.
- On a tlast beat: increment pkt_cnt[ch] using the channel latched at SOP.
- State machine, states WAIT, RUN, DONE:
  - WAIT -> RUN on the first beat.
  - In RUN, idle_cnt increments on every cycle without a beat and resets to 0 on a beat.
  - RUN -> DONE when idle_cnt == IDLE_LIMIT-1 with no beat and arm=1.
  - If arm=0 when the limit is reached, idle_cnt saturates at IDLE_LIMIT. Done asserts on the first cycle arm is high.
  - DONE is sticky. Beats are still counted and checked, and idle_cnt is frozen.
- clear: returns to WAIT and zeroes all counters, last_rank, seen, err_chan and all flags. clear wins over a simultaneous beat; that beat is not counted.
- All counters saturate at all-ones and never wrap.

## Timing
- All outputs are registered. The effect of a beat in cycle N is visible in cycle N+1.
- done rises exactly IDLE_LIMIT idle cycles after the last beat, given arm=1.
- Reset (reset=0) forces WAIT and all outputs to 0 immediately.
- A reset asserted mid-packet discards the partial packet. The next beat after release is treated as SOP.
- The monitor never affects tready; it has no backpressure.

## Configuration
- PIFO_MON_PROTO_CHECK_EN defined:
  - The checker stores tdata, tuser and tlast while tvalid=1 and tready=0.
  - proto_err sets if tvalid drops before a beat.
  - proto_err sets if tdata, tuser or tlast change during a stall.
- Undefined: no storage registers are built and proto_err is constant 0.

## Structure
- Shared package pifo_mon_pkg holds:
  - the state enum (WAIT, RUN, DONE);
  - SUME field offset constants (CHAN_LSB and RANK_LSB defaults);
  - the counter width constant (32);
  - a clog2 function.
- Sub-module pifo_mon_idle_timer contains the idle counter and the WAIT/RUN/DONE FSM. Inputs: beat, arm, clear. Outputs: done, state.
- The top level holds the per-channel arrays and the protocol checker.

## Test plan
- Basic order: ch0 ranks 5, 7, 7, 9 as 1-beat packets -> order_err=0, pkt_cnt[0]=4.
- Order violation: ch2 ranks 10 then 3, with ch1 ranks 3 interleaved -> order_err=1, order_err_cnt=1, err_chan=2, no error on ch1.
- Idle timeout: IDLE_LIMIT=20, arm=1, one 3-beat packet, then idle -> done rises exactly 20 cycles after the tlast beat. With arm=0 held for 50 cycles, done rises 1 cycle after arm goes high.
- Clear collision: clear asserted in the same cycle as a tlast beat on ch3 -> pkt_cnt[3]=0, state WAIT, done=0.
- Protocol (macro defined): tvalid=1, tready=0 for 3 cycles, tuser changed in cycle 2 -> proto_err=1 next cycle. Same stimulus with the macro undefined -> proto_err=0.
- Async reset mid-packet: assert reset after beat 2 of 4, release, send a 1-beat packet on ch0 -> pkt_cnt[0]=1 and it is treated as SOP.
